// File: rtl/song_sequencer_if.sv
// Avalon-style slave bus bundle for the song sequencer: note RAM port plus control register port.
interface song_sequencer_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] note_address;
    logic              note_write;
    logic [31:0]       note_writedata;
    logic [31:0]       note_readdata;
    logic [1:0]        ctrl_address;
    logic              ctrl_write;
    logic [31:0]       ctrl_writedata;
    logic [31:0]       ctrl_readdata;

    modport master (
        output note_address,
        output note_write,
        output note_writedata,
        input  note_readdata,
        output ctrl_address,
        output ctrl_write,
        output ctrl_writedata,
        input  ctrl_readdata
    );

    modport slave (
        input  note_address,
        input  note_write,
        input  note_writedata,
        output note_readdata,
        input  ctrl_address,
        input  ctrl_write,
        input  ctrl_writedata,
        output ctrl_readdata
    );
endinterface

// File: rtl/song_sequencer.sv
// Steps a software-loaded note list into four 8-bit keycode voice slots on a programmable tempo tick.
module song_sequencer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DIV_W  = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    song_sequencer_if.slave     bus,
    output logic [31:0]         song,
    output logic                playing
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StApply = 2'd2;
    localparam logic [1:0] StWait  = 2'd3;

    localparam logic [ADDR_W-1:0] LastStep = ADDR_W'(DEPTH - 1);
    localparam int unsigned       DivPad   = 32 - DIV_W;

    logic [31:0]       mem_q [DEPTH];
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [31:0]       cur_q, cur_d;
    logic [31:0]       song_q, song_d;
    logic [15:0]       dur_cnt_q, dur_cnt_d;
    logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0]  tick_div_q, tick_div_d;
    logic              done_q, done_d;
    logic              run_q, run_d;
    logic              loop_q, loop_d;

    logic [15:0] cur_dur;
    logic [7:0]  cur_key;
    logic [1:0]  cur_slot;
    logic        cur_end;
    logic        ctrl_wr, tempo_wr, stop, start, advance;

    assign cur_dur  = cur_q[31:16];
    assign cur_key  = cur_q[15:8];
    assign cur_slot = cur_q[7:6];
    assign cur_end  = cur_q[0];

    assign ctrl_wr  = bus.ctrl_write && (bus.ctrl_address == 2'd0);
    assign tempo_wr = bus.ctrl_write && (bus.ctrl_address == 2'd1);
    assign stop     = ctrl_wr && !bus.ctrl_writedata[0];
    assign start    = ctrl_wr && bus.ctrl_writedata[0] && (state_q == StIdle);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cur_d      = cur_q;
        song_d     = song_q;
        dur_cnt_d  = dur_cnt_q;
        tick_cnt_d = tick_cnt_q;
        done_d     = done_q;
        run_d      = run_q;
        loop_d     = loop_q;
        tick_div_d = tick_div_q;
        advance    = 1'b0;

        if (ctrl_wr) begin
            loop_d = bus.ctrl_writedata[1];
        end
        if (tempo_wr) begin
            tick_div_d = bus.ctrl_writedata[DIV_W-1:0];
        end

        // Stop suppresses everything else the FSM would do on this edge.
        if (stop) begin
            state_d = StIdle;
            song_d  = '0;
            run_d   = 1'b0;
        end else if (start) begin
            state_d = StFetch;
            step_d  = '0;
            done_d  = 1'b0;
            run_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StFetch: begin
                    cur_d   = mem_q[step_q];
                    state_d = StApply;
                end
                StApply: begin
                    song_d[{cur_slot, 3'b000} +: 8] = cur_key;
                    if (cur_dur != 16'd0) begin
                        dur_cnt_d  = cur_dur;
                        tick_cnt_d = '0;
                        state_d    = StWait;
                    end else begin
                        advance = 1'b1;
                    end
                end
                StWait: begin
                    if (tick_cnt_q == tick_div_q) begin
                        tick_cnt_d = '0;
                        dur_cnt_d  = dur_cnt_q - 16'd1;
                        if (dur_cnt_q == 16'd1) begin
                            advance = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            endcase

            if (advance) begin
                if (cur_end || (step_q == LastStep)) begin
                    song_d = '0;
                    if (loop_q) begin
                        step_d  = '0;
                        state_d = StFetch;
                    end else begin
                        done_d  = 1'b1;
                        run_d   = 1'b0;
                        state_d = StIdle;
                    end
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = StFetch;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            step_q     <= '0;
            cur_q      <= '0;
            song_q     <= '0;
            dur_cnt_q  <= '0;
            tick_cnt_q <= '0;
            tick_div_q <= '0;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cur_q      <= cur_d;
            song_q     <= song_d;
            dur_cnt_q  <= dur_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            tick_div_q <= tick_div_d;
            done_q     <= done_d;
            run_q      <= run_d;
            loop_q     <= loop_d;
        end
    end

    // FETCH samples the old word, so a same-cycle bus write lands after the latch.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.note_write) begin
            mem_q[bus.note_address] <= bus.note_writedata;
        end
    end

    always_comb begin
        unique case (bus.ctrl_address)
            2'd0:    bus.ctrl_readdata = {30'b0, loop_q, run_q};
            2'd1:    bus.ctrl_readdata = {{DivPad{1'b0}}, tick_div_q};
            2'd2:    bus.ctrl_readdata = {16'b0, 8'(step_q), 4'b0, 1'b0, state_q, done_q};
            default: bus.ctrl_readdata = '0;
        endcase
    end

    assign bus.note_readdata = mem_q[bus.note_address];
    assign song              = song_q;
    assign playing           = (state_q != StIdle);

endmodule
